// File: rtl/stereo_pixel_streamer.sv
// Stereo frame source: fetches left/right words from a synchronous pixel memory, applies the
// frame's lane operation and streams beats with VSYNC/HSYNC framing under valid/ready backpressure.
module stereo_pixel_streamer #(
  parameter int WIDTH          = 320,
  parameter int HEIGHT         = 240,
  parameter int PPC            = 2,
  parameter int DW             = 8,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int THRESHOLD      = 90,
  parameter int ADDR_W         = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  input  logic [1:0]          mode,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [PPC*DW-1:0]   mem_rdata_l,
  input  logic [PPC*DW-1:0]   mem_rdata_r,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PPC*DW-1:0]   out_data_l,
  output logic [PPC*DW-1:0]   out_data_r,
  output logic                out_sof,
  output logic                out_eol,
  output logic                out_eof,
  output logic                VSYNC,
  output logic                HSYNC,
  output logic                busy,
  output logic                ctrl_done
);

  localparam int WPL    = WIDTH / PPC;
  localparam int COLW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROWW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PPC_SH = $clog2(PPC);
  localparam int MAXD   = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int DLYW   = $clog2(MAXD + 1);
  localparam int BW     = PPC * DW;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HSYNC, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DLYW-1:0]   dly_q, dly_d;
  logic [1:0]        mode_q, mode_d;
  logic [ROWW-1:0]   row_q, row_d;
  logic [COLW-1:0]   col_q, col_d;
  logic              lineDone_q, lineDone_d;
  logic              infl_q;
  logic [2:0]        inflFlags_q;
  logic [BW-1:0]     fifoL_q [2];
  logic [BW-1:0]     fifoR_q [2];
  logic [2:0]        fifoF_q [2];
  logic              wrPtr_q, rdPtr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop, push, eolPop;
  logic [2:0]        headFlags, issueFlags, pending;
  logic [BW-1:0]     procL, procR;
  logic [DW-1:0]     pl, pr;
  logic [DW:0]       sum;

  // Flags are {eof, eol, sof}; they ride with the read and then with the buffered beat.
  assign headFlags  = fifoF_q[rdPtr_q];
  assign out_valid  = (cnt_q != 2'd0);
  assign out_data_l = fifoL_q[rdPtr_q];
  assign out_data_r = fifoR_q[rdPtr_q];
  assign out_sof    = headFlags[0];
  assign out_eol    = headFlags[1];
  assign out_eof    = headFlags[2];
  assign pop        = out_valid && out_ready;
  assign push       = infl_q;
  assign eolPop     = (state_q == S_DATA) && pop && headFlags[1];
  assign pending    = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
  assign mem_addr   = ADDR_W'(row_q) * ADDR_W'(WPL) + ADDR_W'(col_q >> PPC_SH);

  assign issueFlags[0] = (row_q == '0) && (col_q == '0);
  assign issueFlags[1] = (col_q == COLW'(WIDTH - PPC));
  assign issueFlags[2] = issueFlags[1] && (row_q == ROWW'(HEIGHT - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dly_d   = '0;
    case (state_q)
      S_IDLE:  if (start) begin
                 state_d = S_VSYNC;
                 mode_d  = mode;
               end
      S_VSYNC: if (dly_q == DLYW'(START_UP_DELAY - 1)) state_d = S_HSYNC;
      S_HSYNC: if (dly_q == DLYW'(HSYNC_DELAY - 1)) state_d = S_DATA;
      S_DATA:  if (eolPop) state_d = headFlags[2] ? S_DONE : S_HSYNC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q == S_VSYNC || state_q == S_HSYNC) && state_d == state_q)
      dly_d = dly_q + DLYW'(1);
  end

  // A read is only issued when its beat is guaranteed a buffer slot on return.
  always_comb begin
    VSYNC     = (state_q == S_VSYNC);
    HSYNC     = (state_q == S_DATA);
    busy      = (state_q != S_IDLE);
    ctrl_done = (state_q == S_DONE);
    mem_rd_en = (state_q == S_DATA) && !lineDone_q && (pending < 3'd2);
  end

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    lineDone_d = lineDone_q;
    cnt_d      = cnt_q + 2'(push) - 2'(pop);
    if (mem_rd_en) begin
      if (issueFlags[1]) begin
        col_d      = '0;
        lineDone_d = 1'b1;
      end else begin
        col_d = col_q + COLW'(PPC);
      end
    end
    if (eolPop) begin
      lineDone_d = 1'b0;
      row_d      = headFlags[2] ? '0 : row_q + ROWW'(1);
    end
  end

  always_comb begin
    procL = '0;
    procR = '0;
    pl    = '0;
    pr    = '0;
    sum   = '0;
    for (int k = 0; k < PPC; k++) begin
      pl  = mem_rdata_l[k*DW +: DW];
      pr  = mem_rdata_r[k*DW +: DW];
      sum = {1'b0, pl} + {1'b0, pr};
      case (mode_q)
        2'd0: begin
          procL[k*DW +: DW] = pl;
          procR[k*DW +: DW] = pr;
        end
        2'd1: begin
          procL[k*DW +: DW] = sum[DW:1];
          procR[k*DW +: DW] = sum[DW:1];
        end
        2'd2: begin
          procL[k*DW +: DW] = (pl > pr) ? pl - pr : pr - pl;
          procR[k*DW +: DW] = '0;
        end
        default: begin
          procL[k*DW +: DW] = (pl > DW'(THRESHOLD)) ? '1 : '0;
          procR[k*DW +: DW] = (pr > DW'(THRESHOLD)) ? '1 : '0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      row_q       <= '0;
      col_q       <= '0;
      lineDone_q  <= 1'b0;
      infl_q      <= 1'b0;
      inflFlags_q <= '0;
      wrPtr_q     <= 1'b0;
      rdPtr_q     <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < 2; i++) begin
        fifoL_q[i] <= '0;
        fifoR_q[i] <= '0;
        fifoF_q[i] <= '0;
      end
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      lineDone_q <= lineDone_d;
      infl_q     <= mem_rd_en;
      cnt_q      <= cnt_d;
      if (mem_rd_en) inflFlags_q <= issueFlags;
      if (push) begin
        fifoL_q[wrPtr_q] <= procL;
        fifoR_q[wrPtr_q] <= procR;
        fifoF_q[wrPtr_q] <= inflFlags_q;
        wrPtr_q          <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
    end
  end

endmodule

// File: tb/tb_stereo_pixel_streamer.sv
// Directed bench for stereo_pixel_streamer: expected beats are queued at frame start from a
// memory/arithmetic model and popped against every accepted output beat.
module tb_stereo_pixel_streamer;

  localparam int WIDTH = 8, HEIGHT = 2, PPC = 2, DW = 8, ADDR_W = 8;
  localparam int NWORDS = WIDTH * HEIGHT / PPC;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              start;
  logic [1:0]        mode;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata_l, mem_rdata_r;
  logic              out_valid, out_ready;
  logic [15:0]       out_data_l, out_data_r;
  logic              out_sof, out_eol, out_eof;
  logic              VSYNC, HSYNC, busy, ctrl_done;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] memL [NWORDS];
  logic [15:0] memR [NWORDS];

  int compCount = 0, errCount = 0;
  int cyc = 0, vsyncTotal = 0, doneTotal = 0, beatTotal = 0, stallChecks = 0;
  int issuedTotal = 0, acceptedTotal = 0;
  int gapRun = 0, lastGap = 0, firstAddr = -1, firstRdCyc = 0, firstValidCyc = 0;
  bit everHs = 0, needFirst = 0, needFirstValid = 0, stallHold = 0;
  logic [34:0] holdVal;
  int vs0, done0, beat0, stall0;

  stereo_pixel_streamer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PPC(PPC), .DW(DW),
    .START_UP_DELAY(3), .HSYNC_DELAY(2), .THRESHOLD(90), .ADDR_W(ADDR_W)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata_l(mem_rdata_l), .mem_rdata_r(mem_rdata_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_l(out_data_l), .out_data_r(out_data_r),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .busy(busy), .ctrl_done(ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  // Synchronous pixel memory: data appears the cycle after the read strobe.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mem_rdata_l <= '0;
      mem_rdata_r <= '0;
    end else if (mem_rd_en) begin
      mem_rdata_l <= memL[mem_addr[2:0]];
      mem_rdata_r <= memR[mem_addr[2:0]];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] modelLane(input int m, input int L, input int R, input bit right);
    int lo, ro;
    case (m)
      0: begin lo = L; ro = R; end
      1: begin lo = (L + R) / 2; ro = lo; end
      2: begin lo = (L > R) ? L - R : R - L; ro = 0; end
      default: begin lo = (L > 90) ? 255 : 0; ro = (R > 90) ? 255 : 0; end
    endcase
    return right ? 16'(ro) : 16'(lo);
  endfunction

  task automatic initMem();
    for (int a = 0; a < NWORDS; a++) begin
      memL[a] = {8'(a), 8'(a)};
      memR[a] = {8'(a + 8'h40), 8'(a + 8'h40)};
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m);
    exp_t e;
    int   pL, pR;
    for (int a = 0; a < NWORDS; a++) begin
      e = '0;
      for (int k = 0; k < PPC; k++) begin
        pL = int'(memL[a][k*8 +: 8]);
        pR = int'(memR[a][k*8 +: 8]);
        e.l[k*8 +: 8] = 8'(modelLane(int'(m), pL, pR, 1'b0));
        e.r[k*8 +: 8] = 8'(modelLane(int'(m), pL, pR, 1'b1));
      end
      e.sof = (a == 0);
      e.eol = (a % 4 == 3);
      e.eof = (a == NWORDS - 1);
      expQ.push_back(e);
    end
    vs0 = vsyncTotal; done0 = doneTotal; beat0 = beatTotal; stall0 = stallChecks;
    @(posedge HCLK); #1;
    mode  = m;
    start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
  endtask

  task automatic waitFrameDone(input string tag);
    int n = 0;
    while (doneTotal == done0 && n < 400) begin
      @(negedge HCLK);
      n++;
    end
    checkOutput({tag, "_timeout"}, 64'(n < 400), 64'd1);
    repeat (3) @(negedge HCLK);
    checkOutput({tag, "_done_pulses"}, 64'(doneTotal - done0), 64'd1);
    checkOutput({tag, "_vsync_cycles"}, 64'(vsyncTotal - vs0), 64'd3);
    checkOutput({tag, "_beats"}, 64'(beatTotal - beat0), 64'd8);
    checkOutput({tag, "_queue_left"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
    checkOutput({tag, "_hsync_gap"}, 64'(lastGap), 64'd2);
    checkOutput({tag, "_first_addr"}, 64'(firstAddr), 64'd0);
    checkOutput({tag, "_latency"}, 64'(firstValidCyc - firstRdCyc), 64'd2);
  endtask

  task automatic waitBeats(input int count);
    int n = 0;
    while (beatTotal - beat0 < count && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    checkOutput("wait_beats_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, {15'd0, mem_rd_en, mem_addr, out_valid, out_data_l, out_data_r, out_sof,
                      out_eol, out_eof, VSYNC, HSYNC, busy, ctrl_done}, 64'd0);
  endtask

  // Monitor: framing statistics, stall stability, buffer depth and scoreboard pops.
  always @(negedge HCLK) begin
    exp_t e;
    cyc++;
    if (!HRESETn) begin
      expQ.delete();
      acceptedTotal = issuedTotal;
      stallHold = 0; needFirst = 0; needFirstValid = 0;
    end else begin
      if (VSYNC) begin
        vsyncTotal++; everHs = 0; gapRun = 0; needFirst = 1;
      end
      if (ctrl_done) doneTotal++;
      if (HSYNC) begin
        if (everHs && gapRun > 0) lastGap = gapRun;
        gapRun = 0; everHs = 1;
      end else if (everHs) gapRun++;
      if (mem_rd_en) begin
        issuedTotal++;
        if (needFirst) begin
          firstAddr = int'(mem_addr); firstRdCyc = cyc; needFirst = 0; needFirstValid = 1;
        end
      end
      if (out_valid && needFirstValid) begin
        firstValidCyc = cyc; needFirstValid = 0;
      end
      if (stallHold) begin
        stallChecks++;
        checkOutput("stall_hold", {29'd0, out_valid, out_data_l, out_data_r, out_sof, out_eol, out_eof},
                    {29'd0, 1'b1, holdVal});
      end
      stallHold = out_valid && !out_ready;
      holdVal   = {out_data_l, out_data_r, out_sof, out_eol, out_eof};
      if (out_valid && out_ready) begin
        acceptedTotal++;
        beatTotal++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat_l", 64'(out_data_l), 64'(e.l));
          checkOutput("beat_r", 64'(out_data_r), 64'(e.r));
          checkOutput("beat_flags", {61'd0, out_sof, out_eol, out_eof}, {61'd0, e.sof, e.eol, e.eof});
        end
      end
      if (out_valid && !out_ready)
        checkOutput("buffer_depth", 64'((issuedTotal - acceptedTotal) <= 2), 64'd1);
    end
  end

  initial begin
    HRESETn = 1'b0; start = 1'b0; mode = 2'd0; out_ready = 1'b1;
    initMem();
    repeat (3) @(negedge HCLK);
    checkResetOutputs("reset_outputs");
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    $display("[TB] pass-through frame");
    applyStimulus(2'd0);
    waitFrameDone("pass");

    $display("[TB] average frame");
    initMem();
    memL[0] = 16'h03FF; memR[0] = 16'h0001;
    applyStimulus(2'd1);
    waitFrameDone("avg");

    $display("[TB] absdiff frame");
    initMem();
    memL[1] = 16'h1010; memR[1] = 16'h3030;
    applyStimulus(2'd2);
    waitFrameDone("absdiff");

    $display("[TB] threshold frame");
    initMem();
    memL[2] = 16'h5B5A; memR[2] = 16'hFF00;
    applyStimulus(2'd3);
    waitFrameDone("threshold");

    $display("[TB] backpressure frame");
    initMem();
    applyStimulus(2'd0);
    waitBeats(2);
    @(posedge HCLK); #1;
    out_ready = 1'b0;
    repeat (5) @(posedge HCLK);
    #1 out_ready = 1'b1;
    waitFrameDone("backpressure");
    checkOutput("stall_compares", 64'((stallChecks - stall0) >= 4), 64'd1);

    $display("[TB] reset mid-line");
    applyStimulus(2'd0);
    waitBeats(2);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    @(negedge HCLK);
    checkResetOutputs("midline_reset_outputs");
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    applyStimulus(2'd0);
    waitFrameDone("after_reset");

    $display("[TB] start and mode change mid-frame");
    applyStimulus(2'd1);
    begin
      int n = 0;
      while (!HSYNC && n < 100) begin
        @(negedge HCLK);
        n++;
      end
      checkOutput("wait_data_timeout", 64'(n < 100), 64'd1);
    end
    @(posedge HCLK); #1;
    start = 1'b1; mode = 2'd0;
    @(posedge HCLK); #1;
    start = 1'b0; mode = 2'd2;
    waitFrameDone("midframe_start");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule

// File: doc/stereo_pixel_streamer.md
Name: stereo_pixel_streamer

Overview:
Parametrised stereo frame source. It reads a left and a right image from an external synchronous pixel memory, PPC pixels per word, and streams them with VSYNC/HSYNC framing. Output uses a valid/ready handshake with full backpressure support. A per-frame mode selects pass-through, average, absolute difference or threshold, and the block feeds the disparity and depth pipeline.

Parameters:
WIDTH, 320, image width in pixels; multiple of PPC.
HEIGHT, 240, image height in lines.
PPC, 2, pixels per memory word and per output beat; power of two, 1..8.
DW, 8, bits per pixel.
START_UP_DELAY, 100, VSYNC state length in cycles; must be >=1.
HSYNC_DELAY, 160, inter-line blanking length in cycles; must be >=1.
THRESHOLD, 90, threshold-mode compare value; unsigned, DW bits.
ADDR_W, 16, word address width; must be >= clog2(WIDTH*HEIGHT/PPC).

Ports:
HCLK  in  1  clock; all logic on the rising edge.
HRESETn  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle frame start request; sampled only in IDLE.
mode  in  2  0 pass, 1 average, 2 absdiff, 3 threshold; sampled with start.
mem_rd_en  out  1  memory read strobe.
mem_addr  out  ADDR_W  word address: row*(WIDTH/PPC)+col/PPC.
mem_rdata_l  in  PPC*DW  left word; valid the cycle after mem_rd_en; pixel k at [k*DW +: DW], k=0 leftmost.
mem_rdata_r  in  PPC*DW  right word; same timing and layout.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accept.
out_data_l  out  PPC*DW  processed left lane.
out_data_r  out  PPC*DW  processed right lane.
out_sof  out  1  first beat of frame.
out_eol  out  1  last beat of a line.
out_eof  out  1  last beat of frame.
VSYNC  out  1  high while in VSYNC state.
HSYNC  out  1  high while in DATA state (line active).
busy  out  1  state != IDLE.
ctrl_done  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset: state IDLE; all outputs 0; output buffer emptied; in-flight read discarded; row/col/counters cleared.
- States and transitions:
  - IDLE -> VSYNC on start. Latch mode.
  - VSYNC lasts exactly START_UP_DELAY cycles, then -> HSYNC.
  - HSYNC lasts exactly HSYNC_DELAY cycles, then -> DATA.
  - DATA issues reads for one line, WIDTH/PPC words. It exits on the handshake (out_valid && out_ready) of the eol beat: -> HSYNC if more rows remain, else -> DONE.
  - DONE lasts 1 cycle with ctrl_done=1, then -> IDLE.
- mem_rd_en is asserted only in DATA, and only while the line still has unissued words.
- Issue rule: assert mem_rd_en only if (occupancy + inflight - pop) < 2, where pop = out_valid && out_ready.
- Output buffer: 2-entry FIFO.
  - Read data is captured at the end of the return cycle, so latency from mem_rd_en to out_valid is 2 cycles.
  - Throughput is 1 beat/cycle while out_ready=1.
  - The buffer never overflows.
  - While out_valid && !out_ready, data and flags hold stable.
- Sideband flags travel with the beat:
  - sof on row 0, col 0.
  - eol on col WIDTH-PPC.
  - eof on the eol beat of row HEIGHT-1.
- Mode arithmetic, applied per pixel lane:
  - 0 pass: l=L, r=R.
  - 1 average: l=r=floor((L+R)/2), using a DW+1-bit intermediate.
  - 2 absdiff: l=|L-R|, r=0.
  - 3 threshold: l = (L>THRESHOLD) ? all-ones : 0; r the same using R.
- start outside IDLE is ignored. mode changes mid-frame are ignored.
- Counters:
  - row width clog2(HEIGHT); col steps by PPC and wraps to 0 at WIDTH-PPC.
  - Delay counters are sized for their parameter plus 1 and clear on state exit.
- Reset asserted mid-frame: immediate return to IDLE. A partial beat is never emitted after reset.
- A new frame may start the cycle after DONE, since busy is low in IDLE.

Test Plan:
- Common setup: WIDTH=8, HEIGHT=2, PPC=2, START_UP_DELAY=3, HSYNC_DELAY=2. Memory model returns word address in every pixel (L) and address+0x40 (R).
- Pass mode, out_ready=1 -> 8 beats with l pixels 0x00..0x07 pairs. eol on beats 4 and 8, sof on beat 1, eof on beat 8. VSYNC high exactly 3 cycles. 2-cycle HSYNC-low gap between lines. ctrl_done exactly one pulse, then busy=0.
- Average mode: L=0xFF, R=0x01 -> 0x80. L=0x03, R=0x00 -> 0x01. Absdiff mode: L=0x10, R=0x30 -> l=0x20, r=0x00.
- Threshold mode, THRESHOLD=90: L=90 -> 0x00. L=91 -> 0xFF. R=255 -> 0xFF.
- Backpressure: out_ready low 5 cycles mid-line -> out_data/flags stable, at most 2 beats buffered. The 8 beats are delivered in order with no loss or duplicates.
- Reset pulse mid-line -> all outputs 0 within the reset. The next start yields a full frame starting at mem_addr 0 with sof.
- start pulsed during DATA, and mode changed mid-frame -> no restart, and the latched mode persists to frame end.
